ffa3_fir_stream: RTL

//  3-parallel fast-FIR (FFA) filter, streaming: 3 samples in, 3 filtered samples out per accepted block.

---
 rtl/ffa3_fir_stream_if.sv | 36 +++
 rtl/ffa3_fir_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ffa3_fir_stream_if.sv
// Bus bundle for ffa3_fir_stream: three input sample lanes, the coefficient load port
// and the three filtered output lanes with saturation status.
interface ffa3_fir_stream_if #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int TAP_WIDTH      = 16,
    parameter int TAP_COUNT      = 102
);
    localparam int ADDR_W = $clog2(TAP_COUNT);

    logic                             in_valid;
    logic signed [DATA_IN_WIDTH-1:0]  data_in_0;
    logic signed [DATA_IN_WIDTH-1:0]  data_in_1;
    logic signed [DATA_IN_WIDTH-1:0]  data_in_2;
    logic                             coef_wr;
    logic        [ADDR_W-1:0]         coef_addr;
    logic signed [TAP_WIDTH-1:0]      coef_data;
    logic                             coef_commit;
    logic                             out_valid;
    logic signed [DATA_OUT_WIDTH-1:0] data_out_0;
    logic signed [DATA_OUT_WIDTH-1:0] data_out_1;
    logic signed [DATA_OUT_WIDTH-1:0] data_out_2;
    logic                             sat_flag;

    modport master (
        output in_valid, data_in_0, data_in_1, data_in_2,
        output coef_wr, coef_addr, coef_data, coef_commit,
        input  out_valid, data_out_0, data_out_1, data_out_2, sat_flag
    );

    modport slave (
        input  in_valid, data_in_0, data_in_1, data_in_2,
        input  coef_wr, coef_addr, coef_data, coef_commit,
        output out_valid, data_out_0, data_out_1, data_out_2, sat_flag
    );
endinterface

// File: rtl/ffa3_fir_stream.sv
// 3-parallel fast-FIR (FFA) streaming filter: six TAP_COUNT/3-tap sub-filters, shadow/active
// coefficient banks with atomic commit, fixed 4-stage pipeline and saturating outputs.
module ffa3_fir_stream #(
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 32,
    parameter int TAP_WIDTH      = 16,
    parameter int TAP_COUNT      = 102,
    parameter int ACC_WIDTH      = 48
) (
    input  logic               clk,
    input  logic               reset,
    ffa3_fir_stream_if.slave   bus
);

    localparam int SUB_TAPS = TAP_COUNT / 3;
    localparam int ADDR_W   = $clog2(TAP_COUNT);
    localparam int PRE_W    = DATA_IN_WIDTH + 2;
    localparam int CTAP_W   = TAP_WIDTH + 2;
    localparam int MUL_W    = PRE_W + CTAP_W;

    localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
        ACC_WIDTH'({1'b0, {(DATA_OUT_WIDTH-1){1'b1}}});
    localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = ~OUT_MAX;

    generate
        if ((TAP_COUNT % 3) != 0 || TAP_COUNT < 3 || ACC_WIDTH < DATA_OUT_WIDTH) begin : g_bad_params
            $error("ffa3_fir_stream: TAP_COUNT must be a positive multiple of 3 and ACC_WIDTH >= DATA_OUT_WIDTH");
        end
    endgenerate

    // Sub-filter order everywhere below: H0, H1, H2, H0+H1, H1+H2, H0+H1+H2.
    logic signed [TAP_WIDTH-1:0] r_shadow [3][SUB_TAPS];
    logic signed [TAP_WIDTH-1:0] r_active [3][SUB_TAPS];
    logic signed [CTAP_W-1:0]    w_hc     [6][SUB_TAPS];
    logic signed [PRE_W-1:0]     w_pre    [6];
    logic signed [PRE_W-1:0]     r_dl     [6][SUB_TAPS];
    logic signed [ACC_WIDTH-1:0] w_dot    [6];
    logic signed [ACC_WIDTH-1:0] r_p      [6];
    logic signed [ACC_WIDTH-1:0] r_dP2;
    logic signed [ACC_WIDTH-1:0] r_dT12;
    logic signed [ACC_WIDTH-1:0] w_t0;
    logic signed [ACC_WIDTH-1:0] w_t01;
    logic signed [ACC_WIDTH-1:0] w_t12;
    logic signed [ACC_WIDTH-1:0] w_y    [3];
    logic signed [ACC_WIDTH-1:0] r_y    [3];
    logic signed [DATA_OUT_WIDTH-1:0] w_sat [3];
    logic        [2:0]           w_ovf;
    logic signed [DATA_OUT_WIDTH-1:0] r_out [3];
    logic                        r_v1;
    logic                        r_v2;
    logic                        r_v3;
    logic                        r_outValid;
    logic                        r_sat;

    // Commit samples the shadow bank before any same-cycle write lands, so that write stays shadow-only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 3; p++) begin
                for (int i = 0; i < SUB_TAPS; i++) begin
                    r_shadow[p][i] <= '0;
                    r_active[p][i] <= '0;
                end
            end
        end else begin
            if (bus.coef_commit) begin
                for (int p = 0; p < 3; p++) begin
                    for (int i = 0; i < SUB_TAPS; i++) begin
                        r_active[p][i] <= r_shadow[p][i];
                    end
                end
            end
            if (bus.coef_wr) begin
                for (int n = 0; n < TAP_COUNT; n++) begin
                    if (bus.coef_addr == ADDR_W'(n)) begin
                        r_shadow[n % 3][n / 3] <= bus.coef_data;
                    end
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < SUB_TAPS; i++) begin
            w_hc[0][i] = CTAP_W'(r_active[0][i]);
            w_hc[1][i] = CTAP_W'(r_active[1][i]);
            w_hc[2][i] = CTAP_W'(r_active[2][i]);
            w_hc[3][i] = CTAP_W'(r_active[0][i]) + CTAP_W'(r_active[1][i]);
            w_hc[4][i] = CTAP_W'(r_active[1][i]) + CTAP_W'(r_active[2][i]);
            w_hc[5][i] = CTAP_W'(r_active[0][i]) + CTAP_W'(r_active[1][i]) + CTAP_W'(r_active[2][i]);
        end
    end

    always_comb begin
        w_pre[0] = PRE_W'(bus.data_in_0);
        w_pre[1] = PRE_W'(bus.data_in_1);
        w_pre[2] = PRE_W'(bus.data_in_2);
        w_pre[3] = PRE_W'(bus.data_in_0) + PRE_W'(bus.data_in_1);
        w_pre[4] = PRE_W'(bus.data_in_1) + PRE_W'(bus.data_in_2);
        w_pre[5] = PRE_W'(bus.data_in_0) + PRE_W'(bus.data_in_1) + PRE_W'(bus.data_in_2);
    end

    // Entry 0 of each delay line is the registered S1 sample; history only advances on accepted blocks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                for (int i = 0; i < SUB_TAPS; i++) begin
                    r_dl[k][i] <= '0;
                end
            end
        end else begin
            r_v1 <= bus.in_valid;
            if (bus.in_valid) begin
                for (int k = 0; k < 6; k++) begin
                    r_dl[k][0] <= w_pre[k];
                    for (int i = 1; i < SUB_TAPS; i++) begin
                        r_dl[k][i] <= r_dl[k][i-1];
                    end
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 6; k++) begin
            w_dot[k] = '0;
            for (int i = 0; i < SUB_TAPS; i++) begin
                w_dot[k] = w_dot[k] + ACC_WIDTH'(MUL_W'(r_dl[k][i]) * MUL_W'(w_hc[k][i]));
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v2 <= 1'b0;
            for (int k = 0; k < 6; k++) begin
                r_p[k] <= '0;
            end
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                for (int k = 0; k < 6; k++) begin
                    r_p[k] <= w_dot[k];
                end
            end
        end
    end

    always_comb begin
        w_t0  = r_p[0] - r_dP2;
        w_t01 = r_p[3] - r_p[1];
        w_t12 = r_p[4] - r_p[1];
        w_y[0] = w_t0 + r_dT12;
        w_y[1] = w_t01 - w_t0;
        w_y[2] = r_p[5] - w_t01 - w_t12;
    end

    // r_dP2/r_dT12 are the block-delay terms: they step once per valid block, not per clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v3   <= 1'b0;
            r_dP2  <= '0;
            r_dT12 <= '0;
            for (int j = 0; j < 3; j++) begin
                r_y[j] <= '0;
            end
        end else begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_dP2  <= r_p[2];
                r_dT12 <= w_t12;
                for (int j = 0; j < 3; j++) begin
                    r_y[j] <= w_y[j];
                end
            end
        end
    end

    always_comb begin
        for (int j = 0; j < 3; j++) begin
            w_ovf[j] = 1'b0;
            w_sat[j] = r_y[j][DATA_OUT_WIDTH-1:0];
            if (r_y[j] > OUT_MAX) begin
                w_ovf[j] = 1'b1;
                w_sat[j] = OUT_MAX[DATA_OUT_WIDTH-1:0];
            end else if (r_y[j] < OUT_MIN) begin
                w_ovf[j] = 1'b1;
                w_sat[j] = OUT_MIN[DATA_OUT_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outValid <= 1'b0;
            r_sat      <= 1'b0;
            for (int j = 0; j < 3; j++) begin
                r_out[j] <= '0;
            end
        end else begin
            r_outValid <= r_v3;
            if (r_v3) begin
                r_sat <= r_sat | (|w_ovf);
                for (int j = 0; j < 3; j++) begin
                    r_out[j] <= w_sat[j];
                end
            end
        end
    end

    assign bus.out_valid  = r_outValid;
    assign bus.data_out_0 = r_out[0];
    assign bus.data_out_1 = r_out[1];
    assign bus.data_out_2 = r_out[2];
    assign bus.sat_flag   = r_sat;

endmodule
